// File: rtl/bcd_counter_n_if.sv
// Bundles the control inputs and count/flag outputs of bcd_counter_n.
// The DIGITS parameter must match the counter instance it is attached to.
interface bcd_counter_n_if #(
   parameter int DIGITS = 4
);
   logic                  up;
   logic                  down;
   logic                  clear;
   logic                  set_max;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   num;
   logic                  cout;
   logic                  bout;
   logic                  at_max;
   logic                  at_min;
   logic                  load_err;

   modport master (
      output up, down, clear, set_max, load, load_val,
      input  num, cout, bout, at_max, at_min, load_err
   );

   modport slave (
      input  up, down, clear, set_max, load, load_val,
      output num, cout, bout, at_max, at_min, load_err
   );
endinterface

// File: rtl/bcd_counter_n.sv
// Multi-digit packed-BCD up/down counter with clear, set-max and validated load.
// Wraps or saturates at 0 and 10^DIGITS-1; cout/bout allow cascading instances.
module bcd_counter_n #(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic           clk,
   input  logic           reset,
   bcd_counter_n_if.slave bus
);
   localparam int           W        = 4 * DIGITS;
   localparam logic [W-1:0] ALL_NINE = {DIGITS{4'h9}};
   localparam logic [W-1:0] ALL_ZERO = {W{1'b0}};

   logic [W-1:0] num_q, num_d;
   logic         load_err_q, load_err_d;
   logic [W-1:0] inc_s, dec_s;
   logic         all_nine_s, all_zero_s;
   logic         up_only_s, down_only_s;
   logic         load_ok_s;

   function automatic logic bcd_valid(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         ok = ok & (v[4*k +: 4] <= 4'd9);
      end
      return ok;
   endfunction

   // the carry keeps rippling upward only through digits that roll 9 -> 0
   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         carry;
      r     = v;
      carry = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (carry) begin
            if (v[4*k +: 4] == 4'd9) begin
               r[4*k +: 4] = 4'd0;
               carry       = 1'b1;
            end else begin
               r[4*k +: 4] = v[4*k +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end else begin
            r[4*k +: 4] = v[4*k +: 4];
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (borrow) begin
            if (v[4*k +: 4] == 4'd0) begin
               r[4*k +: 4] = 4'd9;
               borrow      = 1'b1;
            end else begin
               r[4*k +: 4] = v[4*k +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end else begin
            r[4*k +: 4] = v[4*k +: 4];
         end
      end
      return r;
   endfunction

   assign all_nine_s  = (num_q == ALL_NINE);
   assign all_zero_s  = (num_q == ALL_ZERO);
   assign up_only_s   = bus.up & ~bus.down;
   assign down_only_s = bus.down & ~bus.up;
   assign inc_s       = bcd_inc(num_q);
   assign dec_s       = bcd_dec(num_q);
   assign load_ok_s   = bcd_valid(bus.load_val);

   assign bus.num      = num_q;
   assign bus.load_err = load_err_q;
   assign bus.at_max   = all_nine_s;
   assign bus.at_min   = all_zero_s;
   assign bus.cout     = all_nine_s & up_only_s;
   assign bus.bout     = all_zero_s & down_only_s;

   // next count by priority clear > set_max > load > up/down
   always_comb begin
      num_d      = num_q;
      load_err_d = 1'b0;
      if (bus.clear) begin
         num_d = ALL_ZERO;
      end else if (bus.set_max) begin
         num_d = ALL_NINE;
      end else if (bus.load) begin
         if (load_ok_s) begin
            num_d = bus.load_val;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (up_only_s) begin
         if (all_nine_s && (SATURATE == 1'b1)) begin
            num_d = ALL_NINE;
         end else begin
            num_d = inc_s;
         end
      end else if (down_only_s) begin
         if (all_zero_s && (SATURATE == 1'b1)) begin
            num_d = ALL_ZERO;
         end else begin
            num_d = dec_s;
         end
      end else begin
         num_d = num_q;
      end
   end

   // count and load-error registers, synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         num_q      <= ALL_ZERO;
         load_err_q <= 1'b0;
      end else begin
         num_q      <= num_d;
         load_err_q <= load_err_d;
      end
   end
endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: a 4-digit wrapping instance and a 3-digit saturating
// instance, checked against an integer-valued reference model.
module tb_bcd_counter_n;
   logic clk = 1'b0;
   logic rst4, rst3;
   always #5 clk = ~clk;

   bcd_counter_n_if #(.DIGITS(4)) b4 ();
   bcd_counter_n_if #(.DIGITS(3)) b3 ();

   bcd_counter_n #(.DIGITS(4), .SATURATE(1'b0)) dut4 (.clk(clk), .reset(rst4), .bus(b4));
   bcd_counter_n #(.DIGITS(3), .SATURATE(1'b1)) dut3 (.clk(clk), .reset(rst3), .bus(b3));

   int          total = 0;
   int          bad   = 0;
   int          m     [2];
   bit          e_err [2];
   int          dg    [2] = '{4, 3};
   bit          sat   [2] = '{1'b0, 1'b1};
   logic [31:0] o_num;
   logic        o_err;
   logic [3:0]  o_comb;   // {cout, bout, at_max, at_min} just before the edge
   logic [3:0]  x_comb;

   function automatic int top_of(input int d);
      int t;
      t = 1;
      for (int i = 0; i < d; i++) t = t * 10;
      return t - 1;
   endfunction

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      r = 32'd0;
      for (int k = 0; k < 8; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic bit bcd_ok(input logic [31:0] lv, input int d);
      for (int k = 0; k < d; k++) if (lv[4*k +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int from_bcd(input logic [31:0] lv, input int d);
      int r;
      r = 0;
      for (int k = d - 1; k >= 0; k--) r = r * 10 + int'(lv[4*k +: 4]);
      return r;
   endfunction

   // one clock on instance s (other instance idles); updates the model
   task automatic step(input int s, input bit rst, input bit clr, input bit smx, input bit ld,
                       input logic [31:0] lv, input bit u, input bit d);
      int p;
      int top;
      rst4 = 1'b0; b4.clear = 1'b0; b4.set_max = 1'b0; b4.load = 1'b0; b4.up = 1'b0; b4.down = 1'b0;
      rst3 = 1'b0; b3.clear = 1'b0; b3.set_max = 1'b0; b3.load = 1'b0; b3.up = 1'b0; b3.down = 1'b0;
      b4.load_val = lv[15:0];
      b3.load_val = lv[11:0];
      if (s == 0) begin
         rst4 = rst; b4.clear = clr; b4.set_max = smx; b4.load = ld; b4.up = u; b4.down = d;
      end else begin
         rst3 = rst; b3.clear = clr; b3.set_max = smx; b3.load = ld; b3.up = u; b3.down = d;
      end
      @(negedge clk);
      o_comb = (s == 0) ? {b4.cout, b4.bout, b4.at_max, b4.at_min}
                        : {b3.cout, b3.bout, b3.at_max, b3.at_min};
      p   = m[s];
      top = top_of(dg[s]);
      x_comb = {(p == top) && u && !d, (p == 0) && d && !u, p == top, p == 0};
      @(posedge clk);
      e_err[s] = 1'b0;
      if (rst || clr)    m[s] = 0;
      else if (smx)      m[s] = top;
      else if (ld) begin
         if (bcd_ok(lv, dg[s])) m[s] = from_bcd(lv, dg[s]);
         else                   e_err[s] = 1'b1;
      end
      else if (u && !d)  m[s] = (p == top) ? (sat[s] ? top : 0) : p + 1;
      else if (d && !u)  m[s] = (p == 0) ? (sat[s] ? 0 : top) : p - 1;
      #1;
      o_num = (s == 0) ? {16'd0, b4.num} : {20'd0, b3.num};
      o_err = (s == 0) ? b4.load_err : b3.load_err;
   endtask

   task automatic do_load(input int s, input logic [31:0] lv);
      step(s, 1'b0, 1'b0, 1'b0, 1'b1, lv, 1'b0, 1'b0);
   endtask

   task automatic do_cnt(input int s, input bit u, input bit d);
      step(s, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, u, d);
   endtask

   task automatic test_reset();
      for (int s = 0; s < 2; s++) begin
         step(s, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
         total++; if (o_num !== 32'd0) begin bad++; $display("FAIL reset_num[%0d]: got=%h want=0", s, o_num); end
         total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got=%b want=0", s, o_err); end
         do_cnt(s, 1'b0, 1'b0);
         total++; if (o_comb !== 4'b0001) begin bad++; $display("FAIL reset_flags[%0d]: got=%b want=0001", s, o_comb); end
      end
   endtask

   task automatic test_up_wrap();
      logic [3:0] want;
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i <= 9999; i++) begin
         do_cnt(0, 1'b1, 1'b0);
         want = {i == 9999, 1'b0, i == 9999, i == 0};
         total++; if (o_num !== to_bcd((i + 1) % 10000)) begin bad++; $display("FAIL up_wrap_num i=%0d: got=%h want=%h", i, o_num, to_bcd((i + 1) % 10000)); end
         total++; if (o_comb !== want) begin bad++; $display("FAIL up_wrap_flags i=%0d: got=%b want=%b", i, o_comb, want); end
      end
   endtask

   task automatic test_down_wrap();
      step(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      total++; if (o_num !== 32'h9999) begin bad++; $display("FAIL set_max: got=%h want=9999", o_num); end
      for (int i = 1; i <= 3; i++) begin
         do_cnt(0, 1'b0, 1'b1);
         total++; if (o_num !== to_bcd(9999 - i)) begin bad++; $display("FAIL down_%0d: got=%h want=%h", i, o_num, to_bcd(9999 - i)); end
      end
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      do_cnt(0, 1'b0, 1'b1);
      total++; if (o_comb !== 4'b0101) begin bad++; $display("FAIL bout_at_zero: got=%b want=0101", o_comb); end
      total++; if (o_num !== 32'h9999) begin bad++; $display("FAIL down_wrap: got=%h want=9999", o_num); end
   endtask

   task automatic test_saturate();
      do_load(1, 32'h998);
      total++; if (o_num !== 32'h998) begin bad++; $display("FAIL sat_load: got=%h want=998", o_num); end
      for (int i = 0; i < 4; i++) begin
         do_cnt(1, 1'b1, 1'b0);
         total++; if (o_num !== 32'h999) begin bad++; $display("FAIL sat_up i=%0d: got=%h want=999", i, o_num); end
         total++; if (o_comb[3] !== (i > 0)) begin bad++; $display("FAIL sat_cout i=%0d: got=%b want=%b", i, o_comb[3], i > 0); end
      end
      step(1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         do_cnt(1, 1'b0, 1'b1);
         total++; if (o_num !== 32'h000) begin bad++; $display("FAIL sat_down i=%0d: got=%h want=000", i, o_num); end
         total++; if (o_comb !== 4'b0101) begin bad++; $display("FAIL sat_bout i=%0d: got=%b want=0101", i, o_comb); end
      end
   endtask

   task automatic test_digit_boundaries();
      do_load(0, 32'h0199); do_cnt(0, 1'b1, 1'b0);
      total++; if (o_num !== 32'h0200) begin bad++; $display("FAIL bnd_0199_up: got=%h want=0200", o_num); end
      do_load(0, 32'h1000); do_cnt(0, 1'b0, 1'b1);
      total++; if (o_num !== 32'h0999) begin bad++; $display("FAIL bnd_1000_down: got=%h want=0999", o_num); end
      do_load(0, 32'h0909); do_cnt(0, 1'b1, 1'b0);
      total++; if (o_num !== 32'h0910) begin bad++; $display("FAIL bnd_0909_up: got=%h want=0910", o_num); end
      for (int i = 0; i < 5; i++) begin
         do_cnt(0, 1'b1, 1'b1);
         total++; if (o_num !== 32'h0910) begin bad++; $display("FAIL both_num i=%0d: got=%h want=0910", i, o_num); end
         total++; if (o_comb[3:2] !== 2'b00) begin bad++; $display("FAIL both_cout_bout i=%0d: got=%b want=00", i, o_comb[3:2]); end
      end
      do_load(0, 32'h9999); do_cnt(0, 1'b1, 1'b1);
      total++; if (o_comb !== 4'b0010) begin bad++; $display("FAIL both_at_max: got=%b want=0010", o_comb); end
   endtask

   task automatic test_load_validation();
      do_load(0, 32'h0555);
      do_load(0, 32'h12A4);
      total++; if (o_num !== 32'h0555) begin bad++; $display("FAIL bad_load_num: got=%h want=0555", o_num); end
      total++; if (o_err !== 1'b1) begin bad++; $display("FAIL bad_load_err: got=%b want=1", o_err); end
      do_cnt(0, 1'b0, 1'b0);
      total++; if (o_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle: got=%b want=0", o_err); end
      do_load(0, 32'h1234);
      total++; if (o_num !== 32'h1234) begin bad++; $display("FAIL good_load_num: got=%h want=1234", o_num); end
      total++; if (o_err !== 1'b0) begin bad++; $display("FAIL good_load_err: got=%b want=0", o_err); end
   endtask

   task automatic test_priority();
      step(0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234, 1'b1, 1'b0);
      total++; if (o_num !== 32'h0000) begin bad++; $display("FAIL prio_clear: got=%h want=0000", o_num); end
      step(0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1234, 1'b1, 1'b0);
      total++; if (o_num !== 32'h9999) begin bad++; $display("FAIL prio_set_max: got=%h want=9999", o_num); end
      do_load(0, 32'h0456);
      step(0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234, 1'b1, 1'b0);
      total++; if (o_num !== 32'h0000) begin bad++; $display("FAIL prio_reset: got=%h want=0000", o_num); end
      do_cnt(0, 1'b1, 1'b0);
      total++; if (o_num !== 32'h0001) begin bad++; $display("FAIL reset_release: got=%h want=0001", o_num); end
      do_load(1, 32'h5F1);
      step(1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5F1, 1'b1, 1'b0);
      total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset_masks_err: got=%b want=0", o_err); end
   endtask

   task automatic test_random();
      int          s;
      logic [31:0] lv;
      for (int i = 0; i < 4000; i++) begin
         s  = int'($urandom_range(0, 1));
         lv = ($urandom_range(0, 1) == 0) ? to_bcd(int'($urandom_range(0, top_of(dg[s])))) : $urandom;
         step(s, $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0,
              $urandom_range(0, 7) == 0, lv, 1'($urandom), 1'($urandom));
         total++; if (o_num !== to_bcd(m[s])) begin bad++; $display("FAIL rand_num[%0d] i=%0d: got=%h want=%h", s, i, o_num, to_bcd(m[s])); end
         total++; if (o_err !== e_err[s]) begin bad++; $display("FAIL rand_err[%0d] i=%0d: got=%b want=%b", s, i, o_err, e_err[s]); end
         total++; if (o_comb !== x_comb) begin bad++; $display("FAIL rand_flags[%0d] i=%0d: got=%b want=%b", s, i, o_comb, x_comb); end
      end
   endtask

   initial begin
      m[0] = 0; m[1] = 0;
      e_err[0] = 1'b0; e_err[1] = 1'b0;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_saturate();
      test_digit_boundaries();
      test_load_validation();
      test_priority();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
